// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Selects the ID-stage redirect target by priority jr > jmp > branch and
// substitutes the exception vector for misaligned targets.
module fetch_redirect_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        redir,
    output logic        misaligned,
    output logic [31:0] tgt
);

    logic [31:0] raw_tgt;

    always_comb begin
        if (jr) begin
            raw_tgt = jr_target;
        end else if (jmp) begin
            raw_tgt = jmp_target;
        end else begin
            raw_tgt = br_target;
        end
    end

    assign redir      = jr | jmp | br_taken;
    assign misaligned = redir & (raw_tgt[1:0] != 2'b00);
    assign tgt        = misaligned ? EXC_VECTOR : raw_tgt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives pc_next, the imem req/ack handshake and
// the IF/ID register, resolving redirects against stalls and in-flight fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] pc_4,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        addr_err
);

    state_t      state, state_nxt;
    logic        redir, misaligned;
    logic [31:0] tgt;
    logic [31:0] redir_q;
    logic [31:0] skid;
    logic [31:0] if_data;
    logic        if_load, if_kill, skid_ld, redir_ld;

    fetch_redirect_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .jr         (jr),
        .jr_target  (jr_target),
        .redir      (redir),
        .misaligned (misaligned),
        .tgt        (tgt)
    );

    // PC is held while a request is open, so the fetch address is simply pc.
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        pc_next   = pc;
        imem_req  = 1'b0;
        if_load   = 1'b0;
        if_kill   = 1'b0;
        if_data   = imem_rdata;
        skid_ld   = 1'b0;
        redir_ld  = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redir) begin
                    if_kill = 1'b1;
                    if (imem_ack) begin
                        pc_next = tgt;
                    end else begin
                        redir_ld  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        skid_ld   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        if_load = 1'b1;
                        pc_next = pc_4;
                    end
                end else if (!stall) begin
                    if_kill = 1'b1;
                end
            end
            DRAIN: begin
                // Finish the stale request before jumping; a newer redirect wins.
                imem_req = 1'b1;
                if_kill  = 1'b1;
                if (imem_ack) begin
                    pc_next   = redir ? tgt : redir_q;
                    state_nxt = FETCH;
                end else if (redir) begin
                    redir_ld = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    if_kill   = 1'b1;
                    pc_next   = tgt;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    if_load   = 1'b1;
                    if_data   = skid;
                    pc_next   = pc_4;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= 32'h0;
            addr_err <= 1'b0;
            redir_q  <= 32'h0;
        end else begin
            state    <= state_nxt;
            addr_err <= redir & misaligned & (state != BOOT);
            if (redir_ld) begin
                redir_q <= tgt;
            end
            if (if_load) begin
                if_valid <= 1'b1;
                if_instr <= if_data;
                if_pc    <= pc;
            end else if (if_kill) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_ld) begin
            skid <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage core.
- Computes pc_next for the free-running PC register, which loads pc_next every clk and resets to 0.
- Runs the req/ack handshake with instruction memory and owns the IF/ID valid/instr/pc outputs.
- Arbitrates between sequential fetch, ID-stage redirects (branch, j/jal, jr/jalr) and downstream stall, including redirects that arrive while a fetch is still outstanding.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word presented on if_instr whenever if_valid=0.
- EXC_VECTOR, 32'h8000_0180, pc substituted for any misaligned redirect target.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pc  in  32  current PC register value
- pc_4  in  32  pc+4 from PC register
- pc_next  out  32  next PC value to PC register
- stall  in  1  IF/ID hold request from hazard unit
- br_taken  in  1  ID: conditional branch taken
- br_target  in  32  branch target
- jmp  in  1  ID: j/jal
- jmp_target  in  32  jump target
- jr  in  1  ID: jr/jalr
- jr_target  in  32  register target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  data valid this cycle, may coincide with req
- imem_rdata  in  32  instruction word
- if_valid  out  1  IF/ID entry valid
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  IF/ID pc
- addr_err  out  1  one-cycle pulse: misaligned redirect replaced by EXC_VECTOR

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- During reset: state=BOOT, if_valid=0, if_instr=NOP_INSTR, if_pc=0, addr_err=0, imem_req=0, redir_q=0.
- Redirect: redir = jr|jmp|br_taken.
- Redirect target priority: jr_target > jmp_target > br_target. Simultaneous assertion is illegal but resolved by this priority.
- If tgt[1:0]!=0, the target becomes EXC_VECTOR and addr_err pulses 1 on the next cycle.
- Default pc_next=pc (PC holds). imem_addr=pc whenever imem_req=1.
- BOOT: imem_req=0. Next cycle -> FETCH.
- FETCH: imem_req=1.
  - redir & imem_ack: pc_next=tgt. Data dropped; if_valid<=0. Stay in FETCH.
  - redir & !imem_ack: imem_addr must stay stable until ack. redir_q<=tgt, pc_next=pc, if_valid<=0 -> DRAIN.
  - ack & !stall: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc_next=pc_4. Latency: 1 cycle ack-to-if_valid.
  - ack & stall: skid<=rdata, pc_next=pc, IF/ID outputs held -> HOLD.
  - !ack: pc_next=pc. If !stall, if_valid<=0 (bubble); if stall, IF/ID held.
- DRAIN: imem_req=1, addr=pc.
  - On ack: data discarded, pc_next=redir_q -> FETCH.
  - A further redir overwrites redir_q (latest wins).
- HOLD: imem_req=0.
  - redir: skid discarded, pc_next=tgt, if_valid<=0 -> FETCH.
  - !stall: if_instr<=skid, if_pc<=pc, if_valid<=1, pc_next=pc_4 -> FETCH.
  - Otherwise hold.
- Redirect beats stall in every state; IF/ID receives a bubble.
- Width: all addresses 32 bit. pc_4 is taken from the PC register and not recomputed; wrap 32'hFFFF_FFFC -> 0 is natural.
- rst_n asserted in any state aborts immediately. Any outstanding ack after reset release is ignored because BOOT issues no request.

Decomposition:
- Package fetch_pkg: state enum {BOOT, FETCH, DRAIN, HOLD}, NOP_INSTR and EXC_VECTOR defaults.
- One natural sub-module: fetch_redirect_mux (combinational priority select, alignment check, redir flag).

Test Plan:
- Reset release, imem_ack tied 1, rdata=pc: pc sequence 0,0,4,8. if_valid first 1 with if_pc=0, if_instr=0 two cycles after BOOT.
- Branch: at pc=0x10, br_taken=1, br_target=0x40 with ack -> pc_next=0x40, next if_valid=0, then if_pc=0x40.
- DRAIN: ack withheld 3 cycles at pc=0x20, jmp=1 with target 0x100 in cycle 1 -> imem_addr stays 0x20 until ack. Response discarded; next imem_addr=0x100.
- Stall with ack at pc=0x8 -> HOLD, imem_req=0, pc stays 0x8 for 4 stall cycles. Release -> if_pc=0x8, pc_next=0xC.
- jr=1 & jmp=1 together, jr_target=0x202 -> pc_next=0x8000_0180, addr_err pulses once.
- rst_n asserted in DRAIN -> all outputs return to reset values same cycle. No stale redirect after release.
